// File: rtl/id_queue.sv
// id_queue: registered RV32I decode stage between fetch and execute.
// Each accepted instruction is decoded into a packed control word, an immediate
// and an exception code. Results wait in a DEPTH-entry ring buffer.
//
// Ports:
//   clk, rst (async, active-high), flush (sync, drops everything)
//   in_valid/in_ready/in_inst/in_addr       : fetch-side handshake
//   out_valid/out_ready/out_inst/out_addr   : execute-side handshake, head entry
//   out_imm, out_ctrl, out_exc              : decoded head entry (0 when empty)
//   count                                   : occupancy
//
// out_ctrl layout: [32] rd_we | [31:27] rd | [26:22] rs1 | [21:17] rs2 | [16:12] alu |
//   [11:10] op1 | [9:8] op2 | [7:6] mem | [5:3] br | [2:0] wb
//
// Configuration: define ID_QUEUE_MEXT_EN to decode the M extension (OP, funct7=0000001);
// without it those encodings are flagged illegal.
//
// CSR instructions decode with wb=csr, op2=imm (I-format CSR number); the register
// forms (funct3[2]=0) read rs1, the immediate forms leave rs1/op1 at 0. FENCE decodes
// as a legal no-op with an all-zero control word.
module id_queue #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned XLEN   = 32,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_inst,
  input  logic [ADDR_W-1:0]          in_addr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_inst,
  output logic [ADDR_W-1:0]          out_addr,
  output logic [XLEN-1:0]            out_imm,
  output logic [32:0]                out_ctrl,
  output logic [1:0]                 out_exc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  localparam logic [6:0] OpcLui = 7'h37, OpcAuipc = 7'h17, OpcJal = 7'h6f, OpcJalr = 7'h67;
  localparam logic [6:0] OpcBranch = 7'h63, OpcLoad = 7'h03, OpcStore = 7'h23;
  localparam logic [6:0] OpcOpImm = 7'h13, OpcOp = 7'h33, OpcFence = 7'h0f, OpcSystem = 7'h73;

  localparam logic [4:0] AluNop = 5'd0, AluAdd = 5'd1, AluSub = 5'd2, AluXor = 5'd3;
  localparam logic [4:0] AluOr = 5'd4, AluAnd = 5'd5, AluSll = 5'd6, AluSrl = 5'd7;
  localparam logic [4:0] AluSra = 5'd8, AluSlt = 5'd9, AluSltu = 5'd10;

  localparam logic [1:0] ExcNone = 2'd0, ExcIllegal = 2'd1, ExcEcall = 2'd2, ExcEbreak = 2'd3;

  typedef struct packed {
    logic [31:0]       inst;
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   imm;
    logic [32:0]       ctrl;
    logic [1:0]        exc;
  } entry_t;

  // Instruction fields and immediates
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opc   = in_inst[6:0];
  assign rd    = in_inst[11:7];
  assign f3    = in_inst[14:12];
  assign rs1   = in_inst[19:15];
  assign rs2   = in_inst[24:20];
  assign f7    = in_inst[31:25];
  assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8],
                  1'b0};
  assign imm_u = {in_inst[31:12], 12'b0};
  assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21],
                  1'b0};

  // ALU op selected by funct3 for the base (funct7=0) register/immediate forms
  logic [4:0] alu_f3;
  always_comb begin
    case (f3)
      3'd0:    alu_f3 = AluAdd;
      3'd1:    alu_f3 = AluSll;
      3'd2:    alu_f3 = AluSlt;
      3'd3:    alu_f3 = AluSltu;
      3'd4:    alu_f3 = AluXor;
      3'd5:    alu_f3 = AluSrl;
      3'd6:    alu_f3 = AluOr;
      default: alu_f3 = AluAnd;
    endcase
  end

  logic        illegal, has_rd, use_rs1, use_rs2;
  logic [1:0]  sys_exc, op1, op2, mem_op;
  logic [4:0]  alu;
  logic [2:0]  br, wb;
  logic [31:0] imm32;

  always_comb begin
    illegal = 1'b0;
    sys_exc = ExcNone;
    has_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    alu     = AluNop;
    op1     = 2'd0;
    op2     = 2'd0;
    mem_op  = 2'd0;
    br      = 3'd0;
    wb      = 3'd0;
    imm32   = '0;
    if (in_inst[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (opc)
        OpcLui: begin
          has_rd = 1'b1; alu = AluAdd; op2 = 2'd2; wb = 3'd1; imm32 = imm_u;
        end
        OpcAuipc: begin
          has_rd = 1'b1; alu = AluAdd; op1 = 2'd3; op2 = 2'd2; wb = 3'd1; imm32 = imm_u;
        end
        OpcJal: begin
          has_rd = 1'b1; alu = AluAdd; op1 = 2'd3; op2 = 2'd2; br = 3'd1; wb = 3'd3;
          imm32 = imm_j;
        end
        OpcJalr: begin
          has_rd = 1'b1; use_rs1 = 1'b1; alu = AluAdd; op1 = 2'd1; op2 = 2'd2; br = 3'd1;
          wb = 3'd3; imm32 = imm_i; illegal = (f3 != 3'd0);
        end
        OpcBranch: begin
          use_rs1 = 1'b1; use_rs2 = 1'b1; alu = AluSub; op1 = 2'd1; op2 = 2'd1; imm32 = imm_b;
          case (f3)
            3'd0:    br = 3'd2;
            3'd1:    br = 3'd3;
            3'd4:    br = 3'd4;
            3'd5:    br = 3'd5;
            3'd6:    br = 3'd6;
            3'd7:    br = 3'd7;
            default: illegal = 1'b1;
          endcase
        end
        OpcLoad: begin
          has_rd = 1'b1; use_rs1 = 1'b1; alu = AluAdd; op1 = 2'd1; op2 = 2'd2; mem_op = 2'd1;
          wb = 3'd2; imm32 = imm_i; illegal = (f3 == 3'd3) || (f3 >= 3'd6);
        end
        OpcStore: begin
          use_rs1 = 1'b1; use_rs2 = 1'b1; alu = AluAdd; op1 = 2'd1; op2 = 2'd2; mem_op = 2'd2;
          imm32 = imm_s; illegal = (f3 > 3'd2);
        end
        OpcOpImm: begin
          has_rd = 1'b1; use_rs1 = 1'b1; alu = alu_f3; op1 = 2'd1; op2 = 2'd2; wb = 3'd1;
          imm32 = imm_i;
          if (f3 == 3'd1 && f7 != 7'h00) illegal = 1'b1;
          if (f3 == 3'd5) begin
            if (f7 == 7'h20)      alu = AluSra;
            else if (f7 != 7'h00) illegal = 1'b1;
          end
        end
        OpcOp: begin
          has_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; op1 = 2'd1; op2 = 2'd1; wb = 3'd1;
          case (f7)
            7'h00: alu = alu_f3;
            7'h20: begin
              if (f3 == 3'd0)      alu = AluSub;
              else if (f3 == 3'd5) alu = AluSra;
              else                 illegal = 1'b1;
            end
            7'h01: begin
`ifdef ID_QUEUE_MEXT_EN
              alu = {2'b10, f3};
`else
              illegal = 1'b1;
`endif
            end
            default: illegal = 1'b1;
          endcase
        end
        OpcFence: illegal = (f3 != 3'd0);
        OpcSystem: begin
          if (in_inst == 32'h0000_0073) begin
            sys_exc = ExcEcall;
          end else if (in_inst == 32'h0010_0073) begin
            sys_exc = ExcEbreak;
          end else if (f3[1:0] != 2'b00) begin
            has_rd = 1'b1; use_rs1 = ~f3[2]; op1 = f3[2] ? 2'd0 : 2'd1; op2 = 2'd2;
            wb = 3'd4; imm32 = imm_i;
          end else begin
            illegal = 1'b1;
          end
        end
        default: illegal = 1'b1;
      endcase
    end
  end

  entry_t dec_entry;
  always_comb begin
    dec_entry      = '0;
    dec_entry.inst = in_inst;
    dec_entry.addr = in_addr;
    if (illegal) begin
      dec_entry.exc = ExcIllegal;
    end else if (sys_exc != ExcNone) begin
      dec_entry.exc = sys_exc;
    end else begin
      dec_entry.imm  = XLEN'($signed(imm32));
      dec_entry.ctrl = {has_rd && (rd != 5'd0), has_rd ? rd : 5'd0, use_rs1 ? rs1 : 5'd0,
                        use_rs2 ? rs2 : 5'd0, alu, op1, op2, mem_op, br, wb};
    end
  end

  // Ring buffer
  entry_t          mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            push, pop;

  // Held low during reset so fetch cannot push before the queue is live
  assign in_ready  = ~rst & (cnt_q < CntW'(DEPTH));
  assign out_valid = (cnt_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      cnt_d = cnt_q + 1'b1;
      else if (pop && !push) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dec_entry;
  end

  entry_t head;
  always_comb begin
    head = out_valid ? mem_q[rd_ptr_q] : '0;
  end

  assign out_inst = head.inst;
  assign out_addr = head.addr;
  assign out_imm  = head.imm;
  assign out_ctrl = head.ctrl;
  assign out_exc  = head.exc;
  assign count    = cnt_q;

endmodule

// File: tb/tb_id_queue.sv
module tb_id_queue;

  localparam int ADDR_W = 32;
  localparam int XLEN   = 32;
  localparam int DEPTH  = 2;
  localparam int CW     = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]       in_inst, out_inst;
  logic [ADDR_W-1:0] in_addr, out_addr;
  logic [XLEN-1:0]   out_imm;
  logic [32:0]       out_ctrl;
  logic [1:0]        out_exc;
  logic [CW-1:0]     count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0]       inst;
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   imm;
    logic [32:0]       ctrl;
    logic [1:0]        exc;
  } exp_t;

  exp_t model_q[$];

  id_queue #(.ADDR_W(ADDR_W), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_addr(in_addr), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr), .out_imm(out_imm), .out_ctrl(out_ctrl),
    .out_exc(out_exc), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  // Reference decoder built from field arithmetic and lookup tables
  function automatic void ref_decode(input logic [31:0] w, output logic [32:0] ctrl,
                                     output logic [XLEN-1:0] imm, output logic [1:0] exc);
    int op, f3, f7, rd, rs1, rs2, alu, o1, o2, mem, br, wb, iv, sw;
    bit legal, wr, r1, r2;
    int alu_tab [8];
    int br_tab [8];
    longint c;
    alu_tab = '{1, 6, 9, 10, 3, 7, 4, 5};
    br_tab  = '{2, 3, 0, 0, 4, 5, 6, 7};
    op  = int'(w[6:0]);
    rd  = int'(w[11:7]);
    f3  = int'(w[14:12]);
    rs1 = int'(w[19:15]);
    rs2 = int'(w[24:20]);
    f7  = int'(w[31:25]);
    sw  = int'($signed(w));
    legal = 1; wr = 0; r1 = 0; r2 = 0;
    alu = 0; o1 = 0; o2 = 0; mem = 0; br = 0; wb = 0; iv = 0; exc = 2'd0;
    case (op)
      'h37: begin wr = 1; alu = 1; o2 = 2; wb = 1; iv = int'(w & 32'hFFFF_F000); end
      'h17: begin wr = 1; alu = 1; o1 = 3; o2 = 2; wb = 1; iv = int'(w & 32'hFFFF_F000); end
      'h6F: begin
        wr = 1; alu = 1; o1 = 3; o2 = 2; br = 1; wb = 3;
        iv = (sw >>> 31) * (1 << 20) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
             + int'(w[30:21]) * 2;
      end
      'h67: begin
        legal = (f3 == 0); wr = 1; r1 = 1; alu = 1; o1 = 1; o2 = 2; br = 1; wb = 3;
        iv = sw >>> 20;
      end
      'h63: begin
        br = br_tab[f3]; legal = (br != 0); r1 = 1; r2 = 1; alu = 2; o1 = 1; o2 = 1;
        iv = (sw >>> 31) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
      end
      'h03: begin
        legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        wr = 1; r1 = 1; alu = 1; o1 = 1; o2 = 2; mem = 1; wb = 2; iv = sw >>> 20;
      end
      'h23: begin
        legal = (f3 <= 2); r1 = 1; r2 = 1; alu = 1; o1 = 1; o2 = 2; mem = 2;
        iv = (sw >>> 25) * 32 + rd;
      end
      'h13: begin
        wr = 1; r1 = 1; o1 = 1; o2 = 2; wb = 1; iv = sw >>> 20; alu = alu_tab[f3];
        if (f3 == 1) legal = (f7 == 0);
        if (f3 == 5) begin
          if (f7 == 'h20) alu = 8;
          else legal = (f7 == 0);
        end
      end
      'h33: begin
        wr = 1; r1 = 1; r2 = 1; o1 = 1; o2 = 1; wb = 1;
        if (f7 == 0) alu = alu_tab[f3];
        else if (f7 == 'h20 && f3 == 0) alu = 2;
        else if (f7 == 'h20 && f3 == 5) alu = 8;
`ifdef ID_QUEUE_MEXT_EN
        else if (f7 == 1) alu = 16 + f3;
`endif
        else legal = 0;
      end
      'h0F: legal = (f3 == 0);
      'h73: begin
        if (w == 32'h0000_0073) exc = 2'd2;
        else if (w == 32'h0010_0073) exc = 2'd3;
        else if (f3 != 0 && f3 != 4) begin
          wr = 1; r1 = (f3 < 4); o1 = (f3 < 4) ? 1 : 0; o2 = 2; wb = 4; iv = sw >>> 20;
        end else legal = 0;
      end
      default: legal = 0;
    endcase
    c = (wr && rd != 0) ? 1 : 0;
    c = c * 32 + (wr ? rd : 0);
    c = c * 32 + (r1 ? rs1 : 0);
    c = c * 32 + (r2 ? rs2 : 0);
    c = c * 32 + alu;
    c = c * 4 + o1;
    c = c * 4 + o2;
    c = c * 4 + mem;
    c = c * 8 + br;
    c = c * 8 + wb;
    ctrl = c[32:0];
    imm  = XLEN'(iv);
    if (!legal) begin
      ctrl = '0; imm = '0; exc = 2'd1;
    end else if (exc != 2'd0) begin
      ctrl = '0; imm = '0;
    end
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [12];
    logic [6:0] f7s [4];
    logic [31:0] w;
    int k;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h33};
    f7s = '{7'h00, 7'h20, 7'h01, 7'h00};
    w = $urandom;
    k = $urandom_range(0, 15);
    if (k < 12) w[6:0] = ops[k];
    if ($urandom_range(0, 3) != 0) w[31:25] = f7s[$urandom_range(0, 3)];
    if ($urandom_range(0, 19) == 0) w = ($urandom_range(0, 1) == 1) ? 32'h73 : 32'h0010_0073;
    return w;
  endfunction

  // Advances one clock; inputs are set at the negedge, the model follows the handshake rules
  task automatic clock_cycle();
    exp_t e;
    bit do_push, do_pop, do_flush;
    do_flush = flush;
    do_push  = in_valid && !rst && (model_q.size() < DEPTH);
    do_pop   = out_ready && (model_q.size() > 0);
    e.inst = in_inst;
    e.addr = in_addr;
    ref_decode(in_inst, e.ctrl, e.imm, e.exc);
    @(posedge clk);
    if (do_flush) model_q.delete();
    else begin
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0 || count !== '0) begin
      errors++; $display("FAIL reset_state: got valid=%b count=%0d expected 0/0", out_valid, count);
    end
    checks++;
    if (out_inst !== '0 || out_ctrl !== '0 || out_imm !== '0 || out_exc !== '0) begin
      errors++; $display("FAIL reset_data: got inst=%h ctrl=%h expected zeros", out_inst, out_ctrl);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL release_in_ready: got %b expected 1", in_ready);
    end
    model_q.delete();
    @(negedge clk);
  endtask

  task automatic test_addi();
    in_valid = 1'b1; in_inst = 32'h0050_0093; in_addr = 32'h0000_0100; out_ready = 1'b0;
    clock_cycle();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_imm !== 32'd5 || out_exc !== 2'd0) begin
      errors++;
      $display("FAIL addi_head: got valid=%b imm=%h exc=%0d expected 1/5/0",
               out_valid, out_imm, out_exc);
    end
    checks++;
    if (out_ctrl !== 33'h1_0800_1601 || out_addr !== 32'h100 || out_inst !== 32'h0050_0093) begin
      errors++;
      $display("FAIL addi_ctrl: got ctrl=%h addr=%h expected 108001601/100", out_ctrl, out_addr);
    end
    out_ready = 1'b1;
    clock_cycle();
    checks++;
    if (out_valid !== 1'b0 || count !== '0) begin
      errors++; $display("FAIL addi_pop: got valid=%b count=%0d expected 0/0", out_valid, count);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_fill_drain();
    logic [31:0] insts [DEPTH];
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      insts[i] = 32'h0000_0093 | ((i + 1) << 20);
      in_valid = 1'b1; in_inst = insts[i]; in_addr = 32'h200 + 4 * i;
      clock_cycle();
    end
    checks++;
    if (count !== CW'(DEPTH) || in_ready !== 1'b0) begin
      errors++; $display("FAIL fill_full: got count=%0d ready=%b expected %0d/0", count, in_ready,
                         DEPTH);
    end
    in_inst = 32'h0630_0093;
    clock_cycle();
    checks++;
    if (count !== CW'(DEPTH) || out_inst !== insts[0]) begin
      errors++; $display("FAIL fill_holdoff: got count=%0d head=%h expected %0d/%h", count,
                         out_inst, DEPTH, insts[0]);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_inst !== insts[i]) begin
        errors++; $display("FAIL drain_order: got valid=%b inst=%h expected 1/%h", out_valid,
                           out_inst, insts[i]);
      end
      clock_cycle();
    end
    checks++;
    if (count !== '0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL drain_empty: got count=%0d expected 0", count);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_full_pushpop();
    logic [31:0] insts [DEPTH];
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      insts[i] = 32'h0000_0113 | ((i + 10) << 20);
      in_valid = 1'b1; in_inst = insts[i]; in_addr = 32'h300 + 4 * i;
      clock_cycle();
    end
    in_inst = 32'h0000_0013; out_ready = 1'b1;
    clock_cycle();
    checks++;
    if (count !== CW'(DEPTH - 1) || in_ready !== 1'b1 || out_inst !== insts[1]) begin
      errors++; $display("FAIL full_pushpop: got count=%0d ready=%b head=%h expected %0d/1/%h",
                         count, in_ready, out_inst, DEPTH - 1, insts[1]);
    end
    in_valid = 1'b0;
    repeat (DEPTH) clock_cycle();
    out_ready = 1'b0;
  endtask

  task automatic test_exceptions();
    logic [31:0] words [3];
    logic [1:0]  excs [3];
    words = '{32'hFFFF_FFFF, 32'h0000_0073, 32'h0010_0073};
    excs  = '{2'd1, 2'd2, 2'd3};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_inst = words[i]; in_addr = 32'h400 + 4 * i;
      clock_cycle();
      checks++;
      if (out_valid !== 1'b1 || out_exc !== excs[i] || out_ctrl !== '0 || out_imm !== '0) begin
        errors++; $display("FAIL exc_%0d: got exc=%0d ctrl=%h expected %0d/0", i, out_exc,
                           out_ctrl, excs[i]);
      end
    end
    in_valid = 1'b0;
    clock_cycle();
    out_ready = 1'b0;
  endtask

  task automatic test_mext();
    logic [4:0] exp_alu;
    logic [1:0] exp_exc;
`ifdef ID_QUEUE_MEXT_EN
    exp_alu = 5'd16; exp_exc = 2'd0;
`else
    exp_alu = 5'd0; exp_exc = 2'd1;
`endif
    in_valid = 1'b1; in_inst = 32'h0220_81B3; in_addr = 32'h500; out_ready = 1'b0;
    clock_cycle();
    in_valid = 1'b0;
    checks++;
    if (out_ctrl[16:12] !== exp_alu || out_exc !== exp_exc) begin
      errors++; $display("FAIL mext_mul: got alu=%0d exc=%0d expected %0d/%0d", out_ctrl[16:12],
                         out_exc, exp_alu, exp_exc);
    end
    out_ready = 1'b1;
    clock_cycle();
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_inst = 32'h0010_0193 + (i << 20); in_addr = 32'h600 + 4 * i;
      clock_cycle();
    end
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'h0050_0093;
    clock_cycle();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (count !== '0 || out_valid !== 1'b0 || out_inst !== '0) begin
      errors++; $display("FAIL flush: got count=%0d valid=%b expected 0/0", count, out_valid);
    end
    clock_cycle();
    checks++;
    if (count !== '0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_after: got count=%0d ready=%b expected 0/1", count, in_ready);
    end
  endtask

  task automatic test_random();
    exp_t hd;
    logic [CW-1:0] exp_cnt;
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      in_inst   = rand_inst();
      in_addr   = $urandom;
      exp_cnt = CW'(model_q.size());
      if (model_q.size() > 0) hd = model_q[0];
      else begin
        hd.inst = '0; hd.addr = '0; hd.imm = '0; hd.ctrl = '0; hd.exc = '0;
      end
      checks++;
      if (count !== exp_cnt || in_ready !== (model_q.size() < DEPTH)
          || out_valid !== (model_q.size() > 0)) begin
        errors++; $display("FAIL rnd_state[%0d]: got count=%0d ready=%b valid=%b expected count=%0d",
                           c, count, in_ready, out_valid, exp_cnt);
      end
      checks++;
      if (out_inst !== hd.inst || out_addr !== hd.addr) begin
        errors++; $display("FAIL rnd_head[%0d]: got inst=%h addr=%h expected %h/%h", c, out_inst,
                           out_addr, hd.inst, hd.addr);
      end
      checks++;
      if (out_ctrl !== hd.ctrl || out_imm !== hd.imm || out_exc !== hd.exc) begin
        errors++;
        $display("FAIL rnd_decode[%0d] inst=%h: got ctrl=%h imm=%h exc=%0d expected %h/%h/%0d",
                 c, hd.inst, out_ctrl, out_imm, out_exc, hd.ctrl, hd.imm, hd.exc);
      end
      clock_cycle();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_addr = '0;
    test_reset();
    test_addi();
    test_fill_drain();
    test_full_pushpop();
    test_exceptions();
    test_mext();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
